// File: rtl/axi_pkg.sv
// Shared FSM state type and AXI constants for the burst master.
package axi_pkg;

   typedef enum logic [2:0] {IDLE, AW, WD, BR, AR, RD, DONE} axi_state_e;

   localparam logic [1:0]  AXI_BURST_INCR   = 2'b01;
   localparam logic [1:0]  AXI_RESP_OKAY    = 2'b00;
   localparam logic [1:0]  AXI_RESP_SLVERR  = 2'b10;
   localparam int unsigned AXI_4KB_BOUNDARY = 4096;

   // True when a burst starting at this page offset runs past the end of the 4 KB page.
   function automatic logic crosses_4kb(input logic [11:0] addr_lo, input int unsigned len,
                                        input int unsigned bytes);
      return (32'(addr_lo) + len * bytes) > AXI_4KB_BOUNDARY;
   endfunction

endpackage

// File: rtl/axi_burst_master_if.sv
// Command, data-stream and AXI4 channel bundle for axi_burst_master.
interface axi_burst_master_if #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned MAX_LEN = 16
);
   localparam int unsigned LEN_W  = $clog2(MAX_LEN) + 1;
   localparam int unsigned STRB_W = DATA_W / 8;

   logic              cmd_valid, cmd_ready, cmd_we;
   logic [ADDR_W-1:0] cmd_addr;
   logic [LEN_W-1:0]  cmd_len;
   logic              wd_valid, wd_ready;
   logic [DATA_W-1:0] wd_data;
   logic              rd_valid, rd_ready;
   logic [DATA_W-1:0] rd_data;
   logic              done;
   logic [1:0]        resp;

   logic [ADDR_W-1:0] AWADDR, ARADDR;
   logic [7:0]        AWLEN, ARLEN;
   logic [2:0]        AWSIZE, ARSIZE;
   logic [1:0]        AWBURST, ARBURST;
   logic              AWVALID, AWREADY, ARVALID, ARREADY;
   logic [DATA_W-1:0] WDATA, RDATA;
   logic [STRB_W-1:0] WSTRB;
   logic              WLAST, WVALID, WREADY;
   logic [1:0]        BRESP, RRESP;
   logic              BVALID, BREADY;
   logic              RLAST, RVALID, RREADY;

   modport master (
      input  cmd_valid, cmd_we, cmd_addr, cmd_len, wd_valid, wd_data, rd_ready,
             AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RLAST, RVALID,
      output cmd_ready, wd_ready, rd_valid, rd_data, done, resp,
             AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, WDATA, WSTRB, WLAST, WVALID, BREADY,
             ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY
   );

   modport slave (
      output cmd_valid, cmd_we, cmd_addr, cmd_len, wd_valid, wd_data, rd_ready,
             AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RLAST, RVALID,
      input  cmd_ready, wd_ready, rd_valid, rd_data, done, resp,
             AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, WDATA, WSTRB, WLAST, WVALID, BREADY,
             ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY
   );

endinterface

// File: rtl/axi_beat_counter.sv
// Beat counter shared by write and read data phases: counts 1..len, never wraps.
module axi_beat_counter #(
   parameter int unsigned LEN_W = 5
) (
   input  logic             ACLK,
   input  logic             ARESETN,
   input  logic             i_load,
   input  logic [LEN_W-1:0] i_len,
   input  logic             i_inc,
   output logic             o_last
);
   logic [LEN_W-1:0] r_count;
   logic [LEN_W-1:0] r_len;

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_count <= '0;
         r_len   <= '0;
      end else if (i_load) begin
         r_count <= LEN_W'(1);
         r_len   <= i_len;
      end else if (i_inc && !o_last) begin
         r_count <= r_count + LEN_W'(1);
      end
   end

   assign o_last = (r_count == r_len);

endmodule

// File: rtl/axi_burst_master.sv
// Single-outstanding AXI4 INCR burst master driven by a command port and data streams.
// Optional latency counter output enabled by defining AXI_BURST_MASTER_PERF_EN.
module axi_burst_master
   import axi_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned MAX_LEN = 16
) (
   input  logic               ACLK,
   input  logic               ARESETN,
`ifdef AXI_BURST_MASTER_PERF_EN
   output logic [31:0]        lat_cycles,
`endif
   axi_burst_master_if.master bus
);
   localparam int unsigned LEN_W    = $clog2(MAX_LEN) + 1;
   localparam int unsigned STRB_W   = DATA_W / 8;
   localparam logic [2:0]  AXI_SIZE = 3'($clog2(STRB_W));

   axi_state_e        r_state, w_next;
   logic              r_active;
   logic [ADDR_W-1:0] r_addr;
   logic [LEN_W-1:0]  r_len;
   logic [1:0]        r_resp;
   logic              w_accept, w_cross, w_wbeat, w_rbeat, w_last;
   logic [7:0]        w_axlen;

   // r_active keeps cmd_ready low until the first clock edge after reset release.
   assign w_accept = (r_state == IDLE) && r_active && bus.cmd_valid;
   assign w_cross  = crosses_4kb(bus.cmd_addr[11:0], 32'(bus.cmd_len), STRB_W);
   assign w_wbeat  = (r_state == WD) && bus.wd_valid && bus.WREADY;
   assign w_rbeat  = (r_state == RD) && bus.RVALID && bus.rd_ready;
   assign w_axlen  = 8'(r_len - LEN_W'(1));

   axi_beat_counter #(.LEN_W(LEN_W)) u_beat_counter (
      .ACLK    (ACLK),
      .ARESETN (ARESETN),
      .i_load  (w_accept),
      .i_len   (bus.cmd_len),
      .i_inc   (w_wbeat || w_rbeat),
      .o_last  (w_last)
   );

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_state  <= IDLE;
         r_active <= 1'b0;
      end else begin
         r_state  <= w_next;
         r_active <= 1'b1;
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_addr <= '0;
         r_len  <= '0;
         r_resp <= AXI_RESP_OKAY;
      end else if (w_accept) begin
         r_addr <= bus.cmd_addr;
         r_len  <= bus.cmd_len;
         r_resp <= w_cross ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
      end else if ((r_state == BR) && bus.BVALID) begin
         r_resp <= bus.BRESP;
      end else if (w_rbeat) begin
         // A premature RLAST is a protocol error regardless of the beat's own response.
         if (bus.RLAST && !w_last) begin
            r_resp <= AXI_RESP_SLVERR;
         end else if (bus.RRESP > r_resp) begin
            r_resp <= bus.RRESP;
         end
      end
   end

   always_comb begin
      w_next        = r_state;
      bus.cmd_ready = 1'b0;
      bus.AWADDR    = r_addr;
      bus.AWLEN     = w_axlen;
      bus.AWSIZE    = AXI_SIZE;
      bus.AWBURST   = AXI_BURST_INCR;
      bus.AWVALID   = 1'b0;
      bus.ARADDR    = r_addr;
      bus.ARLEN     = w_axlen;
      bus.ARSIZE    = AXI_SIZE;
      bus.ARBURST   = AXI_BURST_INCR;
      bus.ARVALID   = 1'b0;
      bus.WDATA     = bus.wd_data;
      bus.WSTRB     = '1;
      bus.WVALID    = 1'b0;
      bus.WLAST     = 1'b0;
      bus.wd_ready  = 1'b0;
      bus.BREADY    = 1'b0;
      bus.rd_data   = bus.RDATA;
      bus.rd_valid  = 1'b0;
      bus.RREADY    = 1'b0;
      bus.done      = 1'b0;
      bus.resp      = r_resp;
      unique case (r_state)
         IDLE: begin
            bus.cmd_ready = r_active;
            if (w_accept) begin
               if (w_cross)         w_next = DONE;
               else if (bus.cmd_we) w_next = AW;
               else                 w_next = AR;
            end
         end
         AW: begin
            bus.AWVALID = 1'b1;
            if (bus.AWREADY) w_next = WD;
         end
         WD: begin
            bus.WVALID   = bus.wd_valid;
            bus.wd_ready = bus.WREADY;
            bus.WLAST    = w_last;
            if (w_wbeat && w_last) w_next = BR;
         end
         BR: begin
            bus.BREADY = 1'b1;
            if (bus.BVALID) w_next = DONE;
         end
         AR: begin
            bus.ARVALID = 1'b1;
            if (bus.ARREADY) w_next = RD;
         end
         RD: begin
            bus.rd_valid = bus.RVALID;
            bus.RREADY   = bus.rd_ready;
            if (w_rbeat && bus.RLAST) w_next = DONE;
         end
         DONE: begin
            bus.done = 1'b1;
            w_next   = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

`ifdef AXI_BURST_MASTER_PERF_EN
   logic [31:0] r_lat_cnt;
   logic [31:0] w_lat_inc;

   // r_lat_cnt holds the index of the current cycle counted from command accept.
   assign w_lat_inc = (&r_lat_cnt) ? r_lat_cnt : r_lat_cnt + 32'd1;

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_lat_cnt  <= '0;
         lat_cycles <= '0;
      end else begin
         if (r_state == IDLE)      r_lat_cnt <= w_accept ? 32'd1 : 32'd0;
         else if (r_state == DONE) r_lat_cnt <= '0;
         else                      r_lat_cnt <= w_lat_inc;
         if ((r_state != DONE) && (w_next == DONE)) lat_cycles <= w_lat_inc;
      end
   end
`endif

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed self-checking bench for axi_burst_master (32-bit data, 16-beat max).
module tb_axi_burst_master;
   localparam int unsigned ADDR_W  = 32;
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned MAX_LEN = 16;

   logic ACLK = 1'b0;
   logic ARESETN;
   int   n_chk = 0;
   int   n_err = 0;

   axi_burst_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_LEN(MAX_LEN)) bus ();

`ifdef AXI_BURST_MASTER_PERF_EN
   logic [31:0] lat_cycles;
`endif

   axi_burst_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_LEN(MAX_LEN)) dut (
      .ACLK       (ACLK),
      .ARESETN    (ARESETN),
`ifdef AXI_BURST_MASTER_PERF_EN
      .lat_cycles (lat_cycles),
`endif
      .bus        (bus)
   );

   always #5 ACLK = ~ACLK;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic issue_cmd(input logic we, input logic [31:0] addr, input logic [4:0] len);
      @(negedge ACLK);
      bus.cmd_valid = 1'b1;
      bus.cmd_we    = we;
      bus.cmd_addr  = addr;
      bus.cmd_len   = len;
      #1 chk("cmd_ready_idle", bus.cmd_ready, 1'b1);
      @(negedge ACLK);
      bus.cmd_valid = 1'b0;
      #1 chk("cmd_ready_busy", bus.cmd_ready, 1'b0);
   endtask

   task automatic write_burst(input logic [31:0] addr, input logic [4:0] len,
                              input logic [31:0] base, input logic [1:0] bresp);
      issue_cmd(1'b1, addr, len);
      chk("awvalid", bus.AWVALID, 1'b1);
      chk("awaddr", bus.AWADDR, addr);
      chk("awlen", bus.AWLEN, len - 5'd1);
      chk("awsize", bus.AWSIZE, 3'd2);
      chk("awburst", bus.AWBURST, 2'b01);
      bus.AWREADY = 1'b1;
      @(negedge ACLK);
      bus.AWREADY = 1'b0;
      for (int i = 0; i < int'(len); i++) begin
         bus.wd_valid = 1'b1;
         bus.WREADY   = 1'b1;
         bus.wd_data  = base + 32'(i);
         #1;
         chk("wvalid", bus.WVALID, 1'b1);
         chk("wdata", bus.WDATA, base + 32'(i));
         chk("wd_ready", bus.wd_ready, 1'b1);
         chk("wstrb", bus.WSTRB, 4'hF);
         chk("wlast", bus.WLAST, i == int'(len) - 1);
         @(negedge ACLK);
      end
      bus.wd_valid = 1'b0;
      bus.WREADY   = 1'b0;
      #1 chk("bready", bus.BREADY, 1'b1);
      bus.BVALID = 1'b1;
      bus.BRESP  = bresp;
      @(negedge ACLK);
      bus.BVALID = 1'b0;
      bus.BRESP  = 2'b00;
      #1;
      chk("wr_done", bus.done, 1'b1);
      chk("wr_resp", bus.resp, bresp);
      @(negedge ACLK);
      #1;
      chk("wr_done_pulse", bus.done, 1'b0);
      chk("wr_back_idle", bus.cmd_ready, 1'b1);
   endtask

   task automatic read_burst(input logic [31:0] addr, input logic [4:0] len, input int nbeats,
                             input logic [31:0] base, input logic [1:0] exp_resp);
      issue_cmd(1'b0, addr, len);
      chk("arvalid", bus.ARVALID, 1'b1);
      chk("awvalid_on_read", bus.AWVALID, 1'b0);
      chk("araddr", bus.ARADDR, addr);
      chk("arlen", bus.ARLEN, len - 5'd1);
      chk("arburst", bus.ARBURST, 2'b01);
      bus.ARREADY = 1'b1;
      @(negedge ACLK);
      bus.ARREADY = 1'b0;
      for (int i = 0; i < nbeats; i++) begin
         bus.RVALID   = 1'b1;
         bus.RDATA    = base + 32'(i);
         bus.RRESP    = 2'b00;
         bus.RLAST    = (i == nbeats - 1);
         bus.rd_ready = 1'b1;
         #1;
         chk("rd_valid", bus.rd_valid, 1'b1);
         chk("rd_data", bus.rd_data, base + 32'(i));
         chk("rready", bus.RREADY, 1'b1);
         @(negedge ACLK);
      end
      bus.RVALID   = 1'b0;
      bus.RLAST    = 1'b0;
      bus.rd_ready = 1'b0;
      #1;
      chk("rd_done", bus.done, 1'b1);
      chk("rd_resp", bus.resp, exp_resp);
      @(negedge ACLK);
      #1 chk("rd_done_pulse", bus.done, 1'b0);
   endtask

   initial begin
      int beat;
      ARESETN       = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_we    = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_len   = '0;
      bus.wd_valid  = 1'b0;
      bus.wd_data   = '0;
      bus.rd_ready  = 1'b0;
      bus.AWREADY   = 1'b0;
      bus.WREADY    = 1'b0;
      bus.BRESP     = 2'b00;
      bus.BVALID    = 1'b0;
      bus.ARREADY   = 1'b0;
      bus.RDATA     = '0;
      bus.RRESP     = 2'b00;
      bus.RLAST     = 1'b0;
      bus.RVALID    = 1'b0;

      // Reset state
      repeat (2) @(negedge ACLK);
      #1;
      chk("rst_cmd_ready", bus.cmd_ready, 1'b0);
      chk("rst_awvalid", bus.AWVALID, 1'b0);
      chk("rst_arvalid", bus.ARVALID, 1'b0);
      chk("rst_bready", bus.BREADY, 1'b0);
      chk("rst_rready", bus.RREADY, 1'b0);
      chk("rst_done", bus.done, 1'b0);
      chk("rst_resp", bus.resp, 2'b00);
`ifdef AXI_BURST_MASTER_PERF_EN
      chk("rst_lat", lat_cycles, 32'd0);
`endif
      @(negedge ACLK);
      ARESETN = 1'b1;
      #1 chk("no_ready_before_edge", bus.cmd_ready, 1'b0);

      // 4-beat write and read at 0x100
      write_burst(32'h100, 5'd4, 32'hA0, 2'b00);
      read_burst(32'h100, 5'd4, 4, 32'hA0, 2'b00);

      // 16-beat read with rd_ready toggling; beat 5 returns EXOKAY
      issue_cmd(1'b0, 32'h400, 5'd16);
      chk("tog_arlen", bus.ARLEN, 8'd15);
      bus.ARREADY = 1'b1;
      @(negedge ACLK);
      bus.ARREADY = 1'b0;
      beat = 0;
      for (int c = 0; c < 64 && beat < 16; c++) begin
         bus.rd_ready = c[0];
         bus.RVALID   = 1'b1;
         bus.RDATA    = 32'hB0 + 32'(beat);
         bus.RLAST    = (beat == 15);
         bus.RRESP    = (beat == 5) ? 2'b01 : 2'b00;
         #1;
         chk("tog_rready", bus.RREADY, c[0]);
         chk("tog_rd_valid", bus.rd_valid, 1'b1);
         if (bus.rd_ready) begin
            chk("tog_rd_data", bus.rd_data, 32'hB0 + 32'(beat));
            beat++;
         end
         @(negedge ACLK);
      end
      bus.RVALID   = 1'b0;
      bus.RLAST    = 1'b0;
      bus.RRESP    = 2'b00;
      bus.rd_ready = 1'b0;
      #1;
      chk("tog_done", bus.done, 1'b1);
      chk("tog_resp", bus.resp, 2'b01);

      // Premature RLAST on beat 2 of 4
      read_burst(32'h300, 5'd4, 2, 32'hC0, 2'b10);

      // 4 KB crossing is rejected without bus traffic
      issue_cmd(1'b1, 32'hFF8, 5'd4);
      chk("x4k_awvalid", bus.AWVALID, 1'b0);
      chk("x4k_done", bus.done, 1'b1);
      chk("x4k_resp", bus.resp, 2'b10);
      @(negedge ACLK);
      #1;
      chk("x4k_done_pulse", bus.done, 1'b0);
      chk("x4k_awvalid2", bus.AWVALID, 1'b0);
      chk("x4k_idle", bus.cmd_ready, 1'b1);

      // Burst ending exactly at the page end is legal; BRESP=SLVERR is captured
      write_burst(32'hFF0, 5'd4, 32'hD0, 2'b10);

      // Reset after 2 of 8 write beats
      issue_cmd(1'b1, 32'h600, 5'd8);
      bus.AWREADY = 1'b1;
      @(negedge ACLK);
      bus.AWREADY = 1'b0;
      for (int i = 0; i < 2; i++) begin
         bus.wd_valid = 1'b1;
         bus.WREADY   = 1'b1;
         bus.wd_data  = 32'h60 + 32'(i);
         @(negedge ACLK);
      end
      #1 chk("mid_wvalid_before", bus.WVALID, 1'b1);
      ARESETN = 1'b0;
      #1;
      chk("mid_wvalid", bus.WVALID, 1'b0);
      chk("mid_wd_ready", bus.wd_ready, 1'b0);
      chk("mid_wlast", bus.WLAST, 1'b0);
      chk("mid_bready", bus.BREADY, 1'b0);
      chk("mid_cmd_ready", bus.cmd_ready, 1'b0);
      chk("mid_done", bus.done, 1'b0);
      bus.wd_valid = 1'b0;
      bus.WREADY   = 1'b0;
      repeat (2) begin
         @(negedge ACLK);
         #1 chk("mid_no_done", bus.done, 1'b0);
      end
      ARESETN = 1'b1;
      @(negedge ACLK);
      #1 chk("mid_no_done_after", bus.done, 1'b0);
      write_burst(32'h500, 5'd2, 32'hE0, 2'b00);

`ifdef AXI_BURST_MASTER_PERF_EN
      // 1-beat write, AWREADY held off for 3 cycles, immediate WREADY/BVALID
      issue_cmd(1'b1, 32'h200, 5'd1);
      repeat (3) @(negedge ACLK);
      bus.AWREADY  = 1'b1;
      bus.wd_valid = 1'b1;
      bus.WREADY   = 1'b1;
      bus.wd_data  = 32'h77;
      @(negedge ACLK);
      bus.AWREADY = 1'b0;
      bus.BVALID  = 1'b1;
      bus.BRESP   = 2'b00;
      #1 chk("perf_wlast", bus.WLAST, 1'b1);
      @(negedge ACLK);
      bus.wd_valid = 1'b0;
      bus.WREADY   = 1'b0;
      #1 chk("perf_bready", bus.BREADY, 1'b1);
      @(negedge ACLK);
      bus.BVALID = 1'b0;
      #1;
      chk("perf_done", bus.done, 1'b1);
      chk("perf_lat", lat_cycles, 32'd7);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
